// File: rtl/sha_arb_pkg.sv
// Shared types and widths for the SHA core arbiter slice.
package sha_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } arb_state_e;

  localparam int unsigned SHA_DATA_W = 512;
  localparam int unsigned SHA_HASH_W = 256;

endpackage

// File: rtl/sha_core_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to bit 0.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IW = $clog2(N);

  logic found;

  // Upper segment [ptr..N-1] is searched first, then the wrapped segment [0..ptr-1].
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && (j >= 32'(ptr)) && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sha_core_arbiter.sv
// Time-shares one SHA-256 core between N_REQ requesters, one block in flight,
// with a watchdog that turns a missing hash_done into an error response.
module sha_core_arbiter
  import sha_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_W      = SHA_DATA_W,
  parameter int unsigned HASH_W      = SHA_HASH_W,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [HASH_W-1:0]       rsp_hash,
  output logic                    rsp_error,
  output logic [DATA_W-1:0]       core_data,
  output logic                    core_start,
  input  logic [HASH_W-1:0]       core_hash,
  input  logic                    core_done,
  output logic                    busy
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned WW = $clog2(TIMEOUT_CYC);

  arb_state_e        state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     arb_idx;
  logic [N_REQ-1:0]  arb_grant;
  logic [N_REQ-1:0]  grant_q;
  logic [WW-1:0]     wd;
  logic [DATA_W-1:0] sel_data;
  logic              done_ok;
  logic              timeout;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (arb_grant[j]) sel_data = req_data[j*DATA_W +: DATA_W];
    end
  end

  assign req_ready = (state == IDLE) ? arb_grant : '0;
  assign busy      = (state != IDLE);

  // wd is 0 only in the first WAIT cycle, which masks a done level left over from the previous hash.
  // Timeout fires on the cycle the watchdog would step to TIMEOUT_CYC-1.
  assign done_ok = core_done && (wd != '0);
  assign timeout = (wd == WW'(TIMEOUT_CYC - 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      wd         <= '0;
      grant_q    <= '0;
      core_data  <= '0;
      core_start <= 1'b0;
      rsp_valid  <= '0;
      rsp_hash   <= '0;
      rsp_error  <= 1'b0;
    end else begin
      core_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_q    <= arb_grant;
            core_data  <= sel_data;
            ptr        <= (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
            core_start <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wd <= wd + 1'b1;
          if (done_ok) begin
            rsp_hash  <= core_hash;
            rsp_error <= 1'b0;
            rsp_valid <= grant_q;
            state     <= RESP;
          end else if (timeout) begin
            rsp_hash  <= '0;
            rsp_error <= 1'b1;
            rsp_valid <= grant_q;
            state     <= RESP;
          end
        end
        RESP: begin
          if (|(rsp_valid & rsp_ready)) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
